// File: rtl/seg_scan_if.sv
// Load handshake between core logic and the seven-segment scan driver.
// The core side sends a value with its format flags and sees busy and overflow back.
interface seg_scan_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] value;
   logic             load;
   logic             dec_mode;
   logic             blank_lz;
   logic             busy;
   logic             ovf;

   modport master (output value, load, dec_mode, blank_lz, input busy, ovf);
   modport slave  (input value, load, dec_mode, blank_lz, output busy, ovf);
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode seven-segment driver with hex/decimal conversion.
// New digits are committed only on the scan-frame wrap, so the display never tears.
//
// state | meaning
// IDLE  | displaying the active digits, ready to accept a load
// CONV  | hex nibble capture (1 cycle) or double-dabble (WIDTH cycles)
// PEND  | shadow ready, waiting for the frame-boundary tick to commit
module seg_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int WIDTH    = 16,
   parameter int TICK_DIV = 65536
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_scan_if.slave         bus,
   input  logic [DIGITS-1:0] dp_mask,
   output logic [0:6]        sseg,
   output logic              dp,
   output logic [DIGITS-1:0] an
);
   localparam int DBCD = (WIDTH + 2) / 3;
   localparam int NHEX = (WIDTH + 3) / 4;
   localparam int NSH0 = (DBCD > NHEX) ? DBCD : NHEX;
   localparam int NSH  = (NSH0 > DIGITS) ? NSH0 : DIGITS;
   localparam int SW   = 4 * NSH;
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DW   = $clog2(TICK_DIV);
   localparam int CW   = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CONV, PEND} state_t;

   state_t                  state;
   logic [DW-1:0]           div;
   logic [IW-1:0]           idx;
   logic [WIDTH-1:0]        val_sr;
   logic                    dec_q;
   logic                    blz_q;
   logic [CW-1:0]           cnt;
   logic [SW-1:0]           shad;
   logic [DIGITS-1:0][3:0]  act_dig;
   logic [DIGITS-1:0]       act_blank;

   logic                    tick;
   logic                    commit;
   logic [IW-1:0]           idx_nx;
   logic [SW-1:0]           dab_nx;
   logic                    ovf_c;
   logic [DIGITS-1:0]       blank_c;
   logic [DIGITS-1:0][3:0]  act_dig_nx;
   logic [DIGITS-1:0]       act_blank_nx;
   logic                    ovf_nx;
   logic [0:6]              seg_nx;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: glyph = 7'b0000001;
         4'h1: glyph = 7'b1001111;
         4'h2: glyph = 7'b0010010;
         4'h3: glyph = 7'b0000110;
         4'h4: glyph = 7'b1001100;
         4'h5: glyph = 7'b0100100;
         4'h6: glyph = 7'b0100000;
         4'h7: glyph = 7'b0001111;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0000100;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b1100000;
         4'hC: glyph = 7'b0110001;
         4'hD: glyph = 7'b1000010;
         4'hE: glyph = 7'b0110000;
         default: glyph = 7'b0111000;
      endcase
   endfunction

   assign tick   = (div == DW'(TICK_DIV - 1));
   assign commit = (state == PEND) && tick && (idx == IW'(DIGITS - 1));
   assign idx_nx = !tick ? idx : (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
   assign ovf_c  = |(shad >> (4 * DIGITS));

   // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next bit.
   always_comb begin
      logic [SW-1:0] tmp;
      tmp = shad;
      for (int d = 0; d < NSH; d++) begin
         if (tmp[4*d +: 4] >= 4'd5) tmp[4*d +: 4] = tmp[4*d +: 4] + 4'd3;
      end
      dab_nx = {tmp[SW-2:0], val_sr[WIDTH-1]};
   end

   // Blank zeros above the most significant nonzero digit; digit 0 always shows.
   always_comb begin
      logic zero_run;
      blank_c  = '0;
      zero_run = blz_q && !ovf_c;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (shad[4*i +: 4] != 4'd0) zero_run = 1'b0;
         blank_c[i] = zero_run;
      end
   end

   always_comb begin
      act_dig_nx   = act_dig;
      act_blank_nx = act_blank;
      ovf_nx       = bus.ovf;
      if (commit) begin
         for (int i = 0; i < DIGITS; i++) act_dig_nx[i] = shad[4*i +: 4];
         act_blank_nx = blank_c;
         ovf_nx       = ovf_c;
      end
      if (ovf_nx)                    seg_nx = 7'b1111110;
      else if (act_blank_nx[idx_nx]) seg_nx = 7'b1111111;
      else                           seg_nx = glyph(act_dig_nx[idx_nx]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         div       <= '0;
         idx       <= '0;
         val_sr    <= '0;
         dec_q     <= 1'b0;
         blz_q     <= 1'b0;
         cnt       <= '0;
         shad      <= '0;
         act_dig   <= '0;
         act_blank <= '0;
         bus.busy  <= 1'b0;
         bus.ovf   <= 1'b0;
         an        <= '1;
         sseg      <= 7'b1111111;
         dp        <= 1'b1;
      end else begin
         div       <= tick ? '0 : div + DW'(1);
         idx       <= idx_nx;
         act_dig   <= act_dig_nx;
         act_blank <= act_blank_nx;
         bus.ovf   <= ovf_nx;
         if (tick) begin
            an   <= ~(DIGITS'(1) << idx_nx);
            sseg <= seg_nx;
            dp   <= ~dp_mask[idx_nx];
         end
         case (state)
            IDLE: begin
               if (bus.load && !bus.busy) begin
                  val_sr   <= bus.value;
                  dec_q    <= bus.dec_mode;
                  blz_q    <= bus.blank_lz;
                  cnt      <= CW'(WIDTH - 1);
                  shad     <= '0;
                  bus.busy <= 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               if (!dec_q) begin
                  shad  <= SW'(val_sr);
                  state <= PEND;
               end else begin
                  shad   <= dab_nx;
                  val_sr <= val_sr << 1;
                  if (cnt == '0) state <= PEND;
                  else           cnt   <= cnt - CW'(1);
               end
            end
            PEND: begin
               if (commit) begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, WIDTH=16, TICK_DIV=4.
module tb_seg_scan_driver;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] dp_mask;
   logic [0:6] sseg;
   logic       dp;
   logic [3:0] an;

   seg_scan_if #(.WIDTH(16)) bus();

   seg_scan_driver #(.DIGITS(4), .WIDTH(16), .TICK_DIV(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .dp_mask (dp_mask),
      .sseg    (sseg),
      .dp      (dp),
      .an      (an)
   );

   always #5 clk = ~clk;

   int         n_run = 0;
   int         n_fail = 0;
   logic [6:0] fr_seg [4];
   logic       fr_dp  [4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_val(input logic [15:0] v, input logic dec, input logic blz);
      @(negedge clk);
      bus.value    = v;
      bus.dec_mode = dec;
      bus.blank_lz = blz;
      bus.load     = 1'b1;
      @(negedge clk);
      bus.load     = 1'b0;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (bus.busy && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
   endtask

   task automatic grab_frame();
      logic [3:0] seen;
      int         i;
      seen = 4'b0000;
      for (int c = 0; c < 40 && seen != 4'hF; c++) begin
         @(negedge clk);
         i = -1;
         case (an)
            4'b1110: i = 0;
            4'b1101: i = 1;
            4'b1011: i = 2;
            4'b0111: i = 3;
            default: i = -1;
         endcase
         if (i >= 0) begin
            fr_seg[i] = sseg;
            fr_dp[i]  = dp;
            seen[i]   = 1'b1;
         end
      end
      check("frame_all_digits_seen", 32'(seen), 32'hF);
   endtask

   task automatic check_frame(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                              input logic [6:0] d2, input logic [6:0] d3);
      grab_frame();
      check({tag, "_d0"}, 32'(fr_seg[0]), 32'(d0));
      check({tag, "_d1"}, 32'(fr_seg[1]), 32'(d1));
      check({tag, "_d2"}, 32'(fr_seg[2]), 32'(d2));
      check({tag, "_d3"}, 32'(fr_seg[3]), 32'(d3));
   endtask

   initial begin
      int cyc;
      bus.value    = '0;
      bus.load     = 1'b0;
      bus.dec_mode = 1'b0;
      bus.blank_lz = 1'b0;
      dp_mask      = 4'b0000;

      step(2);
      check("rst_an",   32'(an),       32'hF);
      check("rst_sseg", 32'(sseg),     32'h7F);
      check("rst_dp",   32'(dp),       32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ovf",  32'(bus.ovf),  32'd0);
      rst_n = 1'b1;
      step(3);
      check("an_before_tick", 32'(an), 32'hF);
      step(1);
      check("scan_idx1", 32'(an), 32'b1101);
      step(4);
      check("scan_idx2", 32'(an), 32'b1011);
      step(4);
      check("scan_idx3", 32'(an), 32'b0111);
      step(4);
      check("scan_idx0", 32'(an), 32'b1110);

      load_val(16'hA3F0, 1'b0, 1'b0);
      check("hex_busy_rise", 32'(bus.busy), 32'd1);
      wait_idle(cyc);
      check("hex_ovf", 32'(bus.ovf), 32'd0);
      check_frame("hex_a3f0", 7'b0000001, 7'b0111000, 7'b0000110, 7'b0001000);

      load_val(16'd1234, 1'b1, 1'b0);
      check("dec_busy_rise", 32'(bus.busy), 32'd1);
      wait_idle(cyc);
      check("dec_busy_len_ge17", 32'(cyc >= 17), 32'd1);
      check("dec_ovf", 32'(bus.ovf), 32'd0);
      check_frame("dec_1234", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);

      dp_mask = 4'b0010;
      load_val(16'd9, 1'b1, 1'b1);
      wait_idle(cyc);
      check_frame("dec_9_blz", 7'b0000100, 7'b1111111, 7'b1111111, 7'b1111111);
      check("dp_idx0", 32'(fr_dp[0]), 32'd1);
      check("dp_idx1", 32'(fr_dp[1]), 32'd0);
      check("dp_idx2", 32'(fr_dp[2]), 32'd1);
      check("dp_idx3", 32'(fr_dp[3]), 32'd1);
      dp_mask = 4'b0000;

      load_val(16'd65535, 1'b1, 1'b1);
      wait_idle(cyc);
      check("ovf_set", 32'(bus.ovf), 32'd1);
      check_frame("ovf_dash", 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);

      load_val(16'h00FF, 1'b0, 1'b1);
      wait_idle(cyc);
      check("ovf_clear", 32'(bus.ovf), 32'd0);
      check_frame("hex_00ff_blz", 7'b0111000, 7'b0111000, 7'b1111111, 7'b1111111);

      load_val(16'h1234, 1'b0, 1'b0);
      check("first_busy", 32'(bus.busy), 32'd1);
      load_val(16'h5678, 1'b0, 1'b0);
      wait_idle(cyc);
      step(2);
      check("no_queued_load", 32'(bus.busy), 32'd0);
      check_frame("busy_ignore", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);

      load_val(16'd42, 1'b1, 1'b0);
      step(2);
      check("mid_conv_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_an",   32'(an),       32'hF);
      check("abort_sseg", 32'(sseg),     32'h7F);
      check("abort_dp",   32'(dp),       32'd1);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_ovf",  32'(bus.ovf),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(40);
      check("post_abort_busy", 32'(bus.busy), 32'd0);
      check("post_abort_ovf",  32'(bus.ovf),  32'd0);
      check_frame("post_abort", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
